sumsq_seq: RTL and testbench
============================

Name: sumsq_seq

Overview:
- Upstream feeder for the 8-bit odd-subtraction square-root block: takes a signed 2-D vector (X, Y) and produces X*X + Y*Y, so the downstream square root yields the vector magnitude.
- Squares are computed serially with a shift-add multiplier, one partial product per clock, to keep area small.
- Valid/ready handshake on both sides. The 2*W-bit result connects directly to the square root's 8-bit input when W=4.

Parameters:
- W, 4, width of each signed two's-complement input component. Result width is 2*W; the result never overflows, since the maximum is 2*(2^(W-1))^2 = 2^(2W-1).

Ports:
- CLK  input  1  clock; all state changes on rising edge
- RST_N  input  1  reset, synchronous, active-low
- IN_VALID  input  1  X/Y valid
- IN_READY  output  1  block can accept X/Y
- X  input  W  signed component X
- Y  input  W  signed component Y
- OUT_VALID  output  1  OUT_DATA valid
- OUT_READY  input  1  downstream accepts OUT_DATA
- OUT_DATA  output  2*W  X*X + Y*Y, unsigned

Behaviour:
- States: IDLE, SQX, SQY, DONE. Internal registers:
  - MAG_X, MAG_Y: W bits, unsigned
  - ACC: 2*W bits
  - CNT: bit index, range 0..W-1
- Reset: when RST_N is low at a rising edge, state goes to IDLE and ACC, MAG_X, MAG_Y, CNT, OUT_DATA all clear to 0. This gives OUT_VALID=0 and IN_READY=1 in the cycle after reset. Reset mid-operation aborts the current transaction silently; no partial result is ever presented.
- IN_READY = (state==IDLE), decoded from state only. OUT_VALID = (state==DONE).
- IDLE:
  - On an edge with IN_VALID=1, the block captures MAG_X=|X| and MAG_Y=|Y| in W bits, clears ACC and CNT, and goes to SQX.
  - Absolute value is two's-complement negate when the MSB is set. The most negative value maps to 2^(W-1); for W=4, -8 maps to 8 = 4'b1000.
- SQX:
  - Each edge: if MAG_X[CNT]=1 then ACC += MAG_X << CNT (zero-extended to 2*W).
  - CNT increments each edge. On the edge where CNT==W-1, CNT wraps to 0 and the state goes to SQY.
- SQY: same operation using MAG_Y. On the edge where CNT==W-1, OUT_DATA<=ACC+partial and the state goes to DONE.
- Latency: if the input handshake happens at edge k, OUT_VALID is first high in the cycle after edge k+2W (8 cycles for W=4). Latency is fixed and independent of the data.
- DONE: OUT_DATA is held stable while OUT_READY=0, with no limit on the stall. On the edge with OUT_READY=1 the state goes to IDLE.
- No overlap: IN_READY is 0 during DONE even if OUT_READY=1 in that cycle. A new input is first accepted one cycle after the output handshake. Throughput is one result per 2W+2 cycles minimum.
- X and Y are ignored except at the accept edge; changes to them during SQX, SQY or DONE have no effect.
- OUT_DATA retains its last value in IDLE (it is not cleared). Consumers qualify it with OUT_VALID.

Optional Feature:
- Macro SUMSQ_PEAK_EN.
- Defined:
  - Adds output port PEAK, 2*W bits, registered, reset to 0.
  - At each output handshake edge (DONE and OUT_READY=1), PEAK <= max(PEAK, OUT_DATA), unsigned compare.
  - Equal values leave PEAK unchanged. Reset clears PEAK.
- Not defined: the PEAK port and its register are absent, and all other behaviour is identical.

Test Plan:
- Basic: reset, then X=3, Y=4 with OUT_READY=1. Expect IN_READY low for 9 cycles, OUT_VALID high exactly 8 cycles after the accept edge, and OUT_DATA=25 (8'h19).
- Extremes: X=-8, Y=-8 gives 128 (8'h80); X=0, Y=0 gives 0; X=7, Y=-1 gives 50 (8'h32); X=-8, Y=7 gives 113 (8'h71).
- Backpressure: result 25 pending with OUT_READY=0 for 5 cycles. OUT_VALID=1 and OUT_DATA=25 stable throughout, IN_READY=0. Raise OUT_READY for one cycle: OUT_VALID drops next cycle and IN_READY=1.
- Back-to-back: IN_VALID held high with (1,1) then (2,3), OUT_READY=1. Expect outputs 2 then 13, second OUT_VALID 10 cycles after the first.
- Reset mid-operation: assert RST_N=0 for one edge during SQY of (5,5). Next cycle OUT_VALID=0, IN_READY=1, OUT_DATA=0. A following (1,2) yields 5 with normal latency.
- SUMSQ_PEAK_EN: deliver 25, 128, 50. PEAK reads 25, then 128, then stays 128. After reset PEAK=0.

Source files
------------

// File: rtl/sumsq_seq.sv
// rtl/sumsq_seq.sv - serial shift-add X*X+Y*Y feeder for the square-root block
// Optional SUMSQ_PEAK_EN adds a registered running-maximum PEAK output.
module sumsq_seq #(
    parameter int W = 4
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           IN_VALID,
    output logic           IN_READY,
    input  logic [W-1:0]   X,
    input  logic [W-1:0]   Y,
    output logic           OUT_VALID,
    input  logic           OUT_READY,
    output logic [2*W-1:0] OUT_DATA
`ifdef SUMSQ_PEAK_EN
    ,
    output logic [2*W-1:0] PEAK
`endif
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [W-1:0] ONE_W = 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SQX  = 2'd1;
    localparam logic [1:0] S_SQY  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]     r_state;
    logic [W-1:0]   r_mag_x;
    logic [W-1:0]   r_mag_y;
    logic [2*W-1:0] r_acc;
    logic [2*W-1:0] r_out_data;
    logic [CW-1:0]  r_cnt;

    logic [W-1:0]   w_abs_x;
    logic [W-1:0]   w_abs_y;
    logic [W-1:0]   w_mag;
    logic [2*W-1:0] w_partial;
    logic [2*W-1:0] w_sum;
    logic           w_last;

    // The most negative input negates to itself, which read unsigned is 2^(W-1).
    assign w_abs_x = X[W-1] ? (~X + ONE_W) : X;
    assign w_abs_y = Y[W-1] ? (~Y + ONE_W) : Y;

    assign w_mag     = (r_state == S_SQY) ? r_mag_y : r_mag_x;
    assign w_partial = w_mag[r_cnt] ? ({{W{1'b0}}, w_mag} << r_cnt) : '0;
    assign w_sum     = r_acc + w_partial;
    assign w_last    = (r_cnt == CW'(W - 1));

    assign IN_READY  = (r_state == S_IDLE);
    assign OUT_VALID = (r_state == S_DONE);
    assign OUT_DATA  = r_out_data;

`ifdef SUMSQ_PEAK_EN
    logic [2*W-1:0] r_peak;
    assign PEAK = r_peak;
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state    <= S_IDLE;
            r_mag_x    <= '0;
            r_mag_y    <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_out_data <= '0;
`ifdef SUMSQ_PEAK_EN
            r_peak     <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (IN_VALID) begin
                        r_mag_x <= w_abs_x;
                        r_mag_y <= w_abs_y;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_SQX;
                    end
                end
                S_SQX: begin
                    r_acc <= w_sum;
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_state <= S_SQY;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_SQY: begin
                    r_acc <= w_sum;
                    if (w_last) begin
                        r_cnt      <= '0;
                        r_out_data <= w_sum;
                        r_state    <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    // No new accept in this cycle: IN_READY only rises once back in IDLE.
                    if (OUT_READY) begin
                        r_state <= S_IDLE;
`ifdef SUMSQ_PEAK_EN
                        if (r_out_data > r_peak) begin
                            r_peak <= r_out_data;
                        end
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sumsq_seq.sv
// tb/tb_sumsq_seq.sv - randomized and directed self-checking bench for sumsq_seq
// Also covers the PEAK output when built with SUMSQ_PEAK_EN.
module tb_sumsq_seq;

    localparam int W = 4;

    logic           CLK = 1'b0;
    logic           RST_N;
    logic           IN_VALID;
    logic           IN_READY;
    logic [W-1:0]   X;
    logic [W-1:0]   Y;
    logic           OUT_VALID;
    logic           OUT_READY;
    logic [2*W-1:0] OUT_DATA;
`ifdef SUMSQ_PEAK_EN
    logic [2*W-1:0] PEAK;
`endif

    sumsq_seq #(.W(W)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .X         (X),
        .Y         (Y),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_DATA  (OUT_DATA)
`ifdef SUMSQ_PEAK_EN
        ,
        .PEAK      (PEAK)
`endif
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: a transaction is busy for 2W edges, then the result waits for OUT_READY.
    bit chk_en = 1'b0;
    int m_busy = 0;
    bit m_valid = 1'b0;
    int m_pending = 0;
    int m_last = 0;
    int m_peak = 0;
    int sx, sy;

    always @(posedge CLK) begin
        if (!RST_N) begin
            m_busy  = 0;
            m_valid = 1'b0;
            m_last  = 0;
            m_peak  = 0;
        end else if (m_valid) begin
            if (OUT_READY) begin
                m_valid = 1'b0;
                if (m_last > m_peak) m_peak = m_last;
            end
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_valid = 1'b1;
                m_last  = m_pending;
            end
        end else if (IN_VALID) begin
            sx        = $signed(X);
            sy        = $signed(Y);
            m_pending = sx * sx + sy * sy;
            m_busy    = 2 * W;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("cyc_in_ready", IN_READY, (!m_valid && m_busy == 0));
            check("cyc_out_valid", OUT_VALID, m_valid);
            check("cyc_out_data", OUT_DATA, m_last);
`ifdef SUMSQ_PEAK_EN
            check("cyc_peak", PEAK, m_peak);
`endif
        end
    end

    task automatic wait_idle();
        for (int t = 0; t < 40; t++) begin
            if (IN_READY === 1'b1) return;
            @(negedge CLK);
        end
        check("wait_idle_timeout", 0, 1);
    endtask

    // One transaction with OUT_READY held high, literal expected result.
    task automatic do_txn(input logic [W-1:0] x, input logic [W-1:0] y, input int exp, input string nm);
        int lat;
        int low;
        check({nm, "_ready_at_start"}, IN_READY, 1);
        X = x;
        Y = y;
        IN_VALID = 1'b1;
        @(negedge CLK);
        IN_VALID = 1'b0;
        X = W'($urandom);
        Y = W'($urandom);
        lat = -1;
        low = 0;
        for (int t = 1; t <= 40; t++) begin
            if (IN_READY === 1'b1) break;
            low++;
            if (OUT_VALID === 1'b1 && lat < 0) begin
                lat = t;
                check({nm, "_data"}, OUT_DATA, exp);
            end
            @(negedge CLK);
        end
        check({nm, "_latency"}, lat - 1, 2 * W);
        check({nm, "_busy_cycles"}, low, 2 * W + 1);
    endtask

    int t1, t2, d1, d2;

    initial begin
        RST_N = 1'b0;
        IN_VALID = 1'b0;
        X = '0;
        Y = '0;
        OUT_READY = 1'b1;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        chk_en = 1'b1;
        check("reset_in_ready", IN_READY, 1);
        check("reset_out_valid", OUT_VALID, 0);
        check("reset_out_data", OUT_DATA, 0);
`ifdef SUMSQ_PEAK_EN
        check("reset_peak", PEAK, 0);
`endif

        do_txn(4'd3, 4'd4, 25, "basic_3_4");
        do_txn(4'b1000, 4'b1000, 128, "neg8_neg8");
        do_txn(4'd0, 4'd0, 0, "zero_zero");
        do_txn(4'd7, 4'hF, 50, "p7_neg1");
        do_txn(4'b1000, 4'd7, 113, "neg8_p7");

        // Backpressure: result held while OUT_READY is low.
        OUT_READY = 1'b0;
        X = 4'd3;
        Y = 4'd4;
        IN_VALID = 1'b1;
        @(negedge CLK);
        IN_VALID = 1'b0;
        for (int t = 0; t < 40 && OUT_VALID !== 1'b1; t++) @(negedge CLK);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", OUT_VALID, 1);
            check("bp_out_data", OUT_DATA, 25);
            check("bp_in_ready", IN_READY, 0);
            @(negedge CLK);
        end
        OUT_READY = 1'b1;
        @(negedge CLK);
        OUT_READY = 1'b0;
        check("bp_release_valid", OUT_VALID, 0);
        check("bp_release_ready", IN_READY, 1);
        OUT_READY = 1'b1;

        // Back-to-back with IN_VALID held high.
        X = 4'd1;
        Y = 4'd1;
        IN_VALID = 1'b1;
        @(negedge CLK);
        X = 4'd2;
        Y = 4'd3;
        t1 = -1;
        t2 = -1;
        d1 = -1;
        d2 = -1;
        for (int t = 1; t <= 40; t++) begin
            if (OUT_VALID === 1'b1) begin
                if (t1 < 0) begin
                    t1 = t;
                    d1 = OUT_DATA;
                end else begin
                    t2 = t;
                    d2 = OUT_DATA;
                    IN_VALID = 1'b0;
                    break;
                end
            end
            @(negedge CLK);
        end
        IN_VALID = 1'b0;
        check("b2b_first_data", d1, 2);
        check("b2b_second_data", d2, 13);
        check("b2b_spacing", t2 - t1, 2 * W + 2);
        @(negedge CLK);
        wait_idle();

        // Reset while squaring Y of (5,5).
        X = 4'd5;
        Y = 4'd5;
        IN_VALID = 1'b1;
        @(negedge CLK);
        IN_VALID = 1'b0;
        repeat (W + 1) @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        check("midrst_out_valid", OUT_VALID, 0);
        check("midrst_in_ready", IN_READY, 1);
        check("midrst_out_data", OUT_DATA, 0);
        do_txn(4'd1, 4'd2, 5, "after_rst_1_2");

`ifdef SUMSQ_PEAK_EN
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        check("peak_after_reset", PEAK, 0);
        do_txn(4'd3, 4'd4, 25, "peak_25");
        check("peak_is_25", PEAK, 25);
        do_txn(4'b1000, 4'b1000, 128, "peak_128");
        check("peak_is_128", PEAK, 128);
        do_txn(4'd7, 4'hF, 50, "peak_50");
        check("peak_stays_128", PEAK, 128);
`endif

        // Random traffic, random backpressure and rare resets, checked by the model.
        for (int i = 0; i < 600; i++) begin
            IN_VALID  = 1'($urandom % 2);
            X         = W'($urandom);
            Y         = W'($urandom);
            OUT_READY = (($urandom % 4) != 0);
            RST_N     = (($urandom % 150) != 0);
            @(negedge CLK);
        end
        RST_N = 1'b1;
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        @(negedge CLK);
        wait_idle();
        @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
